// File: rtl/nd_1to2_if.sv
// ---------------------------------------------------------------------------
// nd_1to2_if
// Purpose : one NS message channel (four-phase req/ack) carrying an
//           address / data / redundancy message.
// Signals : addr [ASZ]  message address
//           data [DSZ]  message payload
//           red  [RSZ]  message redundancy field
//           req         request, driven by the sender
//           ack         acknowledge, driven by the receiver
// Modports: master = message sender, slave = message receiver.
// ---------------------------------------------------------------------------
interface nd_1to2_if #(
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 8
) ();

  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] data;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output addr, output data, output red, output req, input ack);
  modport slave  (input addr, input data, input red, input req, output ack);

endinterface

// File: rtl/nd_1to2.sv
// ---------------------------------------------------------------------------
// nd_1to2
// Purpose : address-routed 1-to-2 splitter for the NS message network.
//           Messages arrive on one four-phase req/ack channel, are steered
//           by address into one of two FIFOs (addr < 2**(ASZ-1) -> snd0,
//           otherwise snd1) and each FIFO drains on its own output channel.
// Ports   : i_clk    clock, all state changes on the rising edge
//           reset    synchronous reset, active low
//           ready    block initialised and operating
//           err_cnt  count of dropped corrupt messages (saturates at 255)
//           rcv0     input channel  (slave modport)
//           snd0     output channel 0 (master modport)
//           snd1     output channel 1 (master modport)
// Config  : define NS_1TO2_REDUN_CHECK_EN to drop messages whose red field
//           differs from (addr + data) mod 2**RSZ. Without it every message
//           is routed and err_cnt is tied to zero.
// ---------------------------------------------------------------------------
module nd_1to2 #(
  parameter int FSZ = 4,   // per-output FIFO depth, power of two, >= 2
  parameter int ASZ = 8,   // address width (>= 1)
  parameter int DSZ = 8,   // data width
  parameter int RSZ = 8    // redundancy width
) (
  input  logic        i_clk,
  input  logic        reset,
  output logic        ready,
  output logic [7:0]  err_cnt,
  nd_1to2_if.slave    rcv0,
  nd_1to2_if.master   snd0,
  nd_1to2_if.master   snd1
);

  localparam int MW = ASZ + DSZ + RSZ;   // stored message width
  localparam int AW = $clog2(FSZ);       // FIFO slot index width
  localparam int PW = AW + 1;            // pointer width, extra wrap bit
  localparam logic [PW-1:0] P_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_REQ          = 2'd1,
    S_WAIT_ACK_LOW = 2'd2
  } state_t;

  // FIFO is full when the pointers differ only in the wrap bit
  function automatic logic f_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
    return (wp[PW-1] != rp[PW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  function automatic logic f_empty(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
    return (wp == rp);
  endfunction

`ifdef NS_1TO2_REDUN_CHECK_EN
  localparam int SW = ASZ + DSZ + RSZ + 1;  // wide enough for the sum

  // expected redundancy: zero-extended addr + zero-extended data, mod 2**RSZ
  function automatic logic [RSZ-1:0] f_red_expected(input logic [ASZ-1:0] a,
                                                     input logic [DSZ-1:0] d);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(d);
    return s[RSZ-1:0];
  endfunction
`endif

  logic           r_ready;
  logic           r_ack;
  logic           w_new_req;
  logic           w_sel;
  logic           w_red_ok;
  logic           w_tgt_full;
  logic           w_accept;
  logic [1:0]     w_push;
  logic [1:0]     w_full;
  logic [1:0]     w_req;
  logic [1:0]     w_snd_ack;
  logic [MW-1:0]  w_in_msg;
  logic [MW-1:0]  w_msg [2];

  assign w_snd_ack = {snd1.ack, snd0.ack};

  // Input-side decode: new request, routing target, integrity, push strobes
  always_comb begin
    w_new_req = r_ready & rcv0.req & ~r_ack;
    // addr >= 2**(ASZ-1) is exactly "MSB set" for an unsigned ASZ-bit value
    w_sel     = rcv0.addr[ASZ-1];
    w_in_msg  = {rcv0.addr, rcv0.data, rcv0.red};
`ifdef NS_1TO2_REDUN_CHECK_EN
    w_red_ok  = (rcv0.red == f_red_expected(rcv0.addr, rcv0.data));
`else
    w_red_ok  = 1'b1;
`endif
    w_tgt_full = w_sel ? w_full[1] : w_full[0];
    // a corrupt message is acked (and dropped) even if its FIFO is full
    w_accept   = w_new_req & (~w_red_ok | ~w_tgt_full);
    w_push     = 2'b00;
    if (w_new_req && w_red_ok && !w_tgt_full) begin
      if (w_sel) begin
        w_push = 2'b10;
      end else begin
        w_push = 2'b01;
      end
    end else begin
      w_push = 2'b00;
    end
  end

  // Ready flag and input acknowledge; ack drops once req has been released
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_accept) begin
        r_ack <= 1'b1;
      end else if (r_ack && !rcv0.req) begin
        r_ack <= 1'b0;
      end else begin
        r_ack <= r_ack;
      end
    end
  end

`ifdef NS_1TO2_REDUN_CHECK_EN
  logic [7:0] r_err_cnt;

  // Saturating count of corrupt messages dropped on the write edge
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_new_req && !w_red_ok && (r_err_cnt != 8'd255)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign ready     = r_ready;
  assign rcv0.ack  = r_ack;

  // Per-output FIFO and four-phase sender
  for (genvar g = 0; g < 2; g++) begin : g_out
    logic [MW-1:0] r_mem [FSZ];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [MW-1:0] r_msg;
    logic          r_req;
    state_t        r_state;
    state_t        w_next;
    logic          w_pop;
    logic          w_fifo_empty;

    assign w_fifo_empty = f_empty(r_wp, r_rp);
    assign w_full[g]    = f_full(r_wp, r_rp);
    assign w_req[g]     = r_req;
    assign w_msg[g]     = r_msg;

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge i_clk) begin
      if (w_push[g]) begin
        r_mem[r_wp[AW-1:0]] <= w_in_msg;
      end else begin
        r_mem[r_wp[AW-1:0]] <= r_mem[r_wp[AW-1:0]];
      end
    end

    // FIFO pointers, wrapping modulo 2*FSZ
    always_ff @(posedge i_clk) begin
      if (!reset) begin
        r_wp <= {PW{1'b0}};
        r_rp <= {PW{1'b0}};
      end else begin
        r_wp <= w_push[g] ? (r_wp + P_ONE) : r_wp;
        r_rp <= w_pop     ? (r_rp + P_ONE) : r_rp;
      end
    end

    // Sender next-state: load+pop from IDLE, then wait for ack high and low
    always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      if (r_ready) begin
        case (r_state)
          S_IDLE: begin
            if (!w_fifo_empty) begin
              w_next = S_REQ;
              w_pop  = 1'b1;
            end else begin
              w_next = S_IDLE;
            end
          end
          S_REQ: begin
            if (w_snd_ack[g]) begin
              w_next = S_WAIT_ACK_LOW;
            end else begin
              w_next = S_REQ;
            end
          end
          S_WAIT_ACK_LOW: begin
            if (!w_snd_ack[g]) begin
              w_next = S_IDLE;
            end else begin
              w_next = S_WAIT_ACK_LOW;
            end
          end
          default: begin
            w_next = S_IDLE;
          end
        endcase
      end else begin
        w_next = S_IDLE;
        w_pop  = 1'b0;
      end
    end

    // Sender state, request and output message registers
    always_ff @(posedge i_clk) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
        r_msg   <= {MW{1'b0}};
      end else begin
        r_state <= w_next;
        r_req   <= (w_next == S_REQ);
        if (w_pop) begin
          r_msg <= r_mem[r_rp[AW-1:0]];
        end else begin
          r_msg <= r_msg;
        end
      end
    end
  end

  assign snd0.addr = w_msg[0][MW-1 -: ASZ];
  assign snd0.data = w_msg[0][DSZ+RSZ-1 -: DSZ];
  assign snd0.red  = w_msg[0][RSZ-1:0];
  assign snd0.req  = w_req[0];

  assign snd1.addr = w_msg[1][MW-1 -: ASZ];
  assign snd1.data = w_msg[1][DSZ+RSZ-1 -: DSZ];
  assign snd1.red  = w_msg[1][RSZ-1:0];
  assign snd1.req  = w_req[1];

endmodule

// File: tb/tb_nd_1to2.sv
// ---------------------------------------------------------------------------
// tb_nd_1to2
// Purpose : self-checking bench for nd_1to2. Expected messages are queued
//           per output when a request is issued; independent receiver
//           processes pop and compare whenever an output presents a request.
// ---------------------------------------------------------------------------
module tb_nd_1to2;

  localparam int FSZ = 4;
  localparam int ASZ = 8;
  localparam int DSZ = 8;
  localparam int RSZ = 8;
  localparam int MW  = ASZ + DSZ + RSZ;
`ifdef NS_1TO2_REDUN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [7:0] err_cnt;

  nd_1to2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv0_if ();
  nd_1to2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) snd0_if ();
  nd_1to2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) snd1_if ();

  nd_1to2 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk   (clk),
    .reset   (reset),
    .ready   (ready),
    .err_cnt (err_cnt),
    .rcv0    (rcv0_if),
    .snd0    (snd0_if),
    .snd1    (snd1_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [MW-1:0] exp_q0 [$];
  logic [MW-1:0] exp_q1 [$];
  bit hold0 = 1'b0;
  bit hold1 = 1'b0;
  int dmax  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RSZ-1:0] good_red(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d);
    int unsigned s;
    s = int'(a) + int'(d);
    return s[RSZ-1:0];
  endfunction

  // Reference routing: true means output 1
  function automatic bit route1(input logic [ASZ-1:0] a);
    return int'(a) >= (1 << (ASZ - 1));
  endfunction

  task automatic start_req(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d,
                           input logic [RSZ-1:0] r, output bit tgt);
    bit ok;
    tgt = route1(a);
    ok  = !CHECK_EN || (r == good_red(a, d));
    @(negedge clk);
    rcv0_if.addr = a;
    rcv0_if.data = d;
    rcv0_if.red  = r;
    rcv0_if.req  = 1'b1;
    if (ok) begin
      if (tgt) exp_q1.push_back({a, d, r});
      else     exp_q0.push_back({a, d, r});
    end
  endtask

  task automatic finish_req(input bit lat, input bit tgt);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rcv0_if.ack && n < 300);
    chk("ack_rise", rcv0_if.ack, 1);
    if (lat) begin
      chk("ack_latency", n, 1);
      chk("snd_req_early", tgt ? snd1_if.req : snd0_if.req, 0);
    end
    rcv0_if.req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (rcv0_if.ack && n < 20);
    chk("ack_fall", rcv0_if.ack, 0);
    if (lat) begin
      chk("ack_fall_latency", n, 1);
      chk("cut_through_req", tgt ? snd1_if.req : snd0_if.req, 1);
    end
  endtask

  task automatic send(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d,
                      input logic [RSZ-1:0] r, input bit lat);
    bit tgt;
    start_req(a, d, r, tgt);
    finish_req(lat, tgt);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);
  endtask

  // Receiver for output 0
  initial begin : mon0
    int d, n;
    logic [MW-1:0] got, e;
    snd0_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (snd0_if.req && !snd0_if.ack) begin
        got = {snd0_if.addr, snd0_if.data, snd0_if.red};
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL snd0_unexpected: got %0h expected none", got);
        end else begin
          e = exp_q0.pop_front();
          chk("snd0_msg", got, e);
        end
        d = (dmax == 0) ? 0 : int'($urandom_range(dmax, 0));
        repeat (d) @(negedge clk);
        while (hold0) @(negedge clk);
        snd0_if.ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (snd0_if.req && n < 20);
        chk("snd0_req_drop", snd0_if.req, 0);
        snd0_if.ack = 1'b0;
      end
    end
  end

  // Receiver for output 1
  initial begin : mon1
    int d, n;
    logic [MW-1:0] got, e;
    snd1_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (snd1_if.req && !snd1_if.ack) begin
        got = {snd1_if.addr, snd1_if.data, snd1_if.red};
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL snd1_unexpected: got %0h expected none", got);
        end else begin
          e = exp_q1.pop_front();
          chk("snd1_msg", got, e);
        end
        d = (dmax == 0) ? 0 : int'($urandom_range(dmax, 0));
        repeat (d) @(negedge clk);
        while (hold1) @(negedge clk);
        snd1_if.ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (snd1_if.req && n < 20);
        chk("snd1_req_drop", snd1_if.req, 0);
        snd1_if.ack = 1'b0;
      end
    end
  end

  initial begin : stim
    bit tgt;
    bit stale;
    int n;
    logic [ASZ-1:0] a;
    logic [DSZ-1:0] d;

    reset = 1'b0;
    rcv0_if.addr = '0;
    rcv0_if.data = '0;
    rcv0_if.red  = '0;
    rcv0_if.req  = 1'b0;

    // reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {ready, rcv0_if.ack, snd0_if.req, snd1_if.req}, 0);
      chk("reset_err_cnt", err_cnt, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", ready, 1);

`ifdef NS_1TO2_REDUN_CHECK_EN
    // corrupt message acked but dropped, then a good one delivered
    send(8'd3, 8'd5, 8'd7, 1'b0);
    repeat (8) @(negedge clk);
    chk("corrupt_no_output", {snd0_if.req, snd1_if.req}, 0);
    chk("err_cnt_incr", err_cnt, 1);
    send(8'd3, 8'd5, 8'd8, 1'b0);
    drain();
    chk("err_cnt_hold", err_cnt, 1);
`endif

    // routing boundary with latency checks
    dmax = 0;
    send(8'd127, 8'h5a, good_red(8'd127, 8'h5a), 1'b1);
    drain();
    send(8'd128, 8'ha5, good_red(8'd128, 8'ha5), 1'b1);
    drain();

    // head-of-line blocking: output 0 stalled, FSZ in FIFO plus one held
    hold0 = 1'b1;
    for (int i = 0; i < FSZ + 1; i++) begin
      a = 8'(i * 7);
      d = 8'(i + 16);
      send(a, d, good_red(a, d), 1'b0);
    end
    start_req(8'd60, 8'd61, good_red(8'd60, 8'd61), tgt);
    repeat (10) @(negedge clk);
    chk("hol_blocked_ack", rcv0_if.ack, 0);
    hold0 = 1'b0;
    finish_req(1'b0, tgt);
    send(8'd200, 8'd201, good_red(8'd200, 8'd201), 1'b0);
    drain();

    // randomised traffic with random receiver delays
    dmax = 5;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(255, 0));
      d = 8'($urandom_range(255, 0));
      send(a, d, good_red(a, d), 1'b0);
    end
    drain();
    chk("err_cnt_clean", err_cnt, CHECK_EN ? 1 : 0);

    // reset while output 1 is requesting and FIFOs are partly full
    dmax  = 0;
    hold0 = 1'b1;
    hold1 = 1'b1;
    send(8'd130, 8'd1, good_red(8'd130, 8'd1), 1'b0);
    send(8'd10,  8'd2, good_red(8'd10,  8'd2), 1'b0);
    send(8'd140, 8'd3, good_red(8'd140, 8'd3), 1'b0);
    send(8'd20,  8'd4, good_red(8'd20,  8'd4), 1'b0);
    send(8'd150, 8'd5, good_red(8'd150, 8'd5), 1'b0);
    n = 0;
    while (!snd1_if.req && n < 50) begin @(negedge clk); n++; end
    chk("snd1_req_before_reset", snd1_if.req, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_flush", {ready, rcv0_if.ack, snd0_if.req, snd1_if.req}, 0);
    exp_q0.delete();
    exp_q1.delete();
    hold0 = 1'b0;
    hold1 = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rereset", ready, 1);
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (snd0_if.req || snd1_if.req) stale = 1'b1;
    end
    chk("no_stale_output", stale, 0);

    // block still operates after the mid-flight reset
    send(8'd9, 8'd99, good_red(8'd9, 8'd99), 1'b0);
    send(8'd199, 8'd77, good_red(8'd199, 8'd77), 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
